// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared Ethernet/ARP constants for the receive path: EtherType and ARP
// opcodes, preamble/SFD bytes, header lengths, CRC-32 constants, the
// broadcast MAC, the one-hot state encoding of arp_rx, and the byte-wide
// CRC-32 next-state helper used by crc32_d8.
// -----------------------------------------------------------------------------
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam int ETH_HEAD_LEN = 14;
  localparam int ARP_LEN      = 28;

  // Counter terminal values derived from the lengths above.
  localparam logic [4:0] PREAMBLE_CNT  = 5'd7;
  localparam logic [4:0] ETH_HEAD_LAST = 5'(ETH_HEAD_LEN - 1);
  localparam logic [4:0] ARP_LAST      = 5'(ARP_LEN - 1);

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam logic [47:0] MAC_BROADCAST = 48'hFF_FF_FF_FF_FF_FF;

  // One-hot FSM encoding.
  localparam logic [4:0] ST_IDLE     = 5'b00001;
  localparam logic [4:0] ST_PREAMBLE = 5'b00010;
  localparam logic [4:0] ST_ETH_HEAD = 5'b00100;
  localparam logic [4:0] ST_ARP_DATA = 5'b01000;
  localparam logic [4:0] ST_RX_END   = 5'b10000;

  // One byte of CRC-32. The register is kept MSB-first while the data bits
  // enter LSB-first, which is the bit-mirrored form of the reflected
  // Ethernet CRC; in this form the good-frame residue is 32'hC704DD7B.
  function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc,
                                                input logic [7:0]  data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/arp_rx_crc32_d8.sv
// -----------------------------------------------------------------------------
// crc32_d8
// Byte-wide CRC-32 register (poly 0x04C11DB7, init 0xFFFFFFFF, reflected
// data). Only instantiated when ARP_RX_FCS_CHECK_EN is defined.
// Ports:
//   clk    - clock
//   resetn - asynchronous active-low reset (register -> init value)
//   clr    - synchronous clear to init value (priority over en)
//   en     - fold data into the CRC this cycle
//   data   - input byte
//   crc    - current CRC register value
// -----------------------------------------------------------------------------
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_r;

  // CRC state register: clear, accumulate or hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc_r <= CRC_INIT;
    end else if (clr) begin
      crc_r <= CRC_INIT;
    end else if (en) begin
      crc_r <= crc32_d8_next(crc_r, data);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/arp_rx.sv
// -----------------------------------------------------------------------------
// arp_rx
// Receive-side ARP parser. Locks onto preamble/SFD on the GMII byte stream,
// filters on destination MAC (BOARD_MAC or broadcast), EtherType 0x0806,
// opcode 1/2 and target IP == BOARD_IP, and publishes the sender MAC/IP and
// opcode of each accepted packet.
// Optional build macro: ARP_RX_FCS_CHECK_EN -- adds a CRC-32 check over
// destination MAC .. FCS and defers the accept to the falling edge of valid.
// Ports:
//   clk, resetn     - clock, asynchronous active-low reset
//   gmii_rxd_valid  - frame envelope
//   gmii_rxd_data   - receive byte
//   arp_rx_done     - one-cycle pulse per accepted ARP packet
//   arp_rx_type     - 0 = request, 1 = reply (updated with done)
//   src_mac, src_ip - sender addresses of the last accepted packet
// -----------------------------------------------------------------------------
module arp_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        gmii_rxd_valid,
  input  logic [7:0]  gmii_rxd_data,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  logic [4:0]  state_r;
  logic [4:0]  cnt_r;
  logic        err_r;
  logic        mac_not_board_r;
  logic        mac_not_bcast_r;
  logic [47:0] stage_mac_r;
  logic [31:0] stage_ip_r;
  logic        stage_type_r;

  logic        byte_err_s;
  logic        mac_not_board_s;
  logic        mac_not_bcast_s;
  logic [5:0]  mac_sh_s;
  logic [4:0]  ip_sh_s;
  logic [7:0]  board_byte_s;
  logic [7:0]  ip_byte_s;
  logic        accept_s;
  logic        publish_s;

  // Byte of BOARD_MAC / BOARD_IP that lines up with the current counter.
  assign mac_sh_s     = 6'd40 - {cnt_r[2:0], 3'b000};
  assign ip_sh_s      = 5'd24 - {cnt_r[1:0], 3'b000};
  assign board_byte_s = 8'(BOARD_MAC >> mac_sh_s);
  assign ip_byte_s    = 8'(BOARD_IP >> ip_sh_s);

  // Per-byte field checks for the header currently being received.
  always_comb begin
    byte_err_s      = 1'b0;
    mac_not_board_s = mac_not_board_r;
    mac_not_bcast_s = mac_not_bcast_r;
    case (state_r)
      ST_ETH_HEAD: begin
        if (cnt_r < 5'd6) begin
          mac_not_board_s = mac_not_board_r | (gmii_rxd_data != board_byte_s);
          mac_not_bcast_s = mac_not_bcast_r | (gmii_rxd_data != 8'hFF);
        end else if (cnt_r == 5'd12) begin
          byte_err_s = (gmii_rxd_data != ETH_TYPE_ARP[15:8]);
        end else if (cnt_r == 5'd13) begin
          byte_err_s = (gmii_rxd_data != ETH_TYPE_ARP[7:0]);
        end else begin
          byte_err_s = 1'b0;
        end
      end
      ST_ARP_DATA: begin
        if (cnt_r == 5'd6) begin
          byte_err_s = (gmii_rxd_data != 8'h00);
        end else if (cnt_r == 5'd7) begin
          byte_err_s = (gmii_rxd_data != ARP_OP_REQ[7:0]) &&
                       (gmii_rxd_data != ARP_OP_REPLY[7:0]);
        end else if (cnt_r >= 5'd24) begin
          byte_err_s = (gmii_rxd_data != ip_byte_s);
        end else begin
          byte_err_s = 1'b0;
        end
      end
      default: begin
        byte_err_s = 1'b0;
      end
    endcase
  end

  // Last ARP byte with every check clean.
  assign accept_s = (state_r == ST_ARP_DATA) && gmii_rxd_valid &&
                    (cnt_r == ARP_LAST) && !(err_r | byte_err_s);

  // Frame FSM, counters, error flags and sender staging registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 5'd0;
      err_r           <= 1'b0;
      mac_not_board_r <= 1'b0;
      mac_not_bcast_r <= 1'b0;
      stage_mac_r     <= 48'h0;
      stage_ip_r      <= 32'h0;
      stage_type_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r           <= 5'd0;
          err_r           <= 1'b0;
          mac_not_board_r <= 1'b0;
          mac_not_bcast_r <= 1'b0;
          if (gmii_rxd_valid) begin
            if (gmii_rxd_data == PREAMBLE_BYTE) begin
              state_r <= ST_PREAMBLE;
              cnt_r   <= 5'd1;
            end else begin
              state_r <= ST_RX_END;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_rxd_valid) begin
            state_r <= ST_IDLE;
          end else if ((gmii_rxd_data == PREAMBLE_BYTE) && (cnt_r < PREAMBLE_CNT)) begin
            cnt_r <= cnt_r + 5'd1;
          end else if ((gmii_rxd_data == SFD_BYTE) && (cnt_r == PREAMBLE_CNT)) begin
            state_r <= ST_ETH_HEAD;
            cnt_r   <= 5'd0;
          end else begin
            state_r <= ST_RX_END;
          end
        end
        ST_ETH_HEAD: begin
          if (!gmii_rxd_valid) begin
            state_r <= ST_IDLE;
          end else begin
            err_r           <= err_r | byte_err_s;
            mac_not_board_r <= mac_not_board_s;
            mac_not_bcast_r <= mac_not_bcast_s;
            if (cnt_r == ETH_HEAD_LAST) begin
              cnt_r <= 5'd0;
              // Address fails only if it matches neither the board nor broadcast.
              if (err_r | byte_err_s | (mac_not_board_s & mac_not_bcast_s)) begin
                state_r <= ST_RX_END;
              end else begin
                state_r <= ST_ARP_DATA;
              end
            end else begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
        end
        ST_ARP_DATA: begin
          if (!gmii_rxd_valid) begin
            state_r <= ST_IDLE;
          end else begin
            err_r <= err_r | byte_err_s;
            if (cnt_r == 5'd7) begin
              stage_type_r <= (gmii_rxd_data == ARP_OP_REPLY[7:0]);
            end
            if ((cnt_r >= 5'd8) && (cnt_r <= 5'd13)) begin
              stage_mac_r <= {stage_mac_r[39:0], gmii_rxd_data};
            end
            if ((cnt_r >= 5'd14) && (cnt_r <= 5'd17)) begin
              stage_ip_r <= {stage_ip_r[23:0], gmii_rxd_data};
            end
            if (cnt_r == ARP_LAST) begin
              state_r <= ST_RX_END;
              cnt_r   <= 5'd0;
            end else begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
        end
        ST_RX_END: begin
          // Padding and FCS are swallowed here until the envelope closes.
          if (!gmii_rxd_valid) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 5'd0;
        end
      endcase
    end
  end

`ifdef ARP_RX_FCS_CHECK_EN
  logic        pend_r;
  logic        crc_en_s;
  logic [31:0] crc_s;

  // CRC covers destination MAC through the last FCS byte.
  assign crc_en_s = gmii_rxd_valid &&
                    ((state_r == ST_ETH_HEAD) || (state_r == ST_ARP_DATA) ||
                     (state_r == ST_RX_END));

  crc32_d8 u_crc32_d8 (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state_r == ST_IDLE),
    .en     (crc_en_s),
    .data   (gmii_rxd_data),
    .crc    (crc_s)
  );

  // Header-accept flag held until the envelope closes and the CRC is judged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      pend_r <= 1'b0;
    end else if (accept_s) begin
      pend_r <= 1'b1;
    end else begin
      pend_r <= pend_r;
    end
  end

  assign publish_s = (state_r == ST_RX_END) && !gmii_rxd_valid && pend_r &&
                     (crc_s == CRC_RESIDUE);
`else
  assign publish_s = accept_s;
`endif

  // Published outputs: done pulses once, addresses/type load only on accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= 48'h0;
      src_ip      <= 32'h0;
    end else if (publish_s) begin
      arp_rx_done <= 1'b1;
      arp_rx_type <= stage_type_r;
      src_mac     <= stage_mac_r;
      src_ip      <= stage_ip_r;
    end else begin
      arp_rx_done <= 1'b0;
    end
  end

endmodule
